// File: rtl/load_store_buffer_pkg.sv
// Shared constants and types for the load/store buffer.
//   LSB_BIT_P / ROB_BIT_P : default queue-depth exponent and ROB tag width
//   IO_HI                 : addr[17:16] pattern that marks an MMIO access
//   F3_*                  : funct3 size/sign codes for loads and stores
//   lsb_state_e           : memory-port FSM state encoding
//   is_mmio()             : MMIO address classifier
package load_store_buffer_pkg;

    localparam int         LSB_BIT_P = 3;
    localparam int         ROB_BIT_P = 4;
    localparam logic [1:0] IO_HI     = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } lsb_state_e;

    function automatic logic is_mmio(input logic [31:0] addr);
        return (addr[17:16] == IO_HI);
    endfunction

endpackage

// File: rtl/load_store_buffer_ext.sv
// Load data extender: turns the raw little-endian word returned by memory
// into the architectural 32-bit result according to funct3.
//   funct3_i : size/sign code of the load
//   raw_i    : raw memory data, valid bytes in the low lanes
//   ext_o    : sign- or zero-extended result
module lsb_load_ext
    import load_store_buffer_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] ext_o
);

    // Select extension by access size and signedness
    always_comb begin
        ext_o = raw_i;
        case (funct3_i)
            F3_LB:   ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_LH:   ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_LW:   ext_o = raw_i;
            F3_LBU:  ext_o = {24'h000000, raw_i[7:0]};
            F3_LHU:  ext_o = {16'h0000, raw_i[15:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue between dispatch/address ALU and the memory
// controller. Entries hold ops in program order, pick up addresses by ROB
// tag and store data from the CDB; the head issues one request at a time.
// Stores reach memory only after commit; loads return extended data.
//   clk_in/rst_in/rdy_in      : clock, async active-low reset, global stall
//   disp_*  / lsb_full        : dispatch port and full indication
//   addr_*                    : address ALU results
//   cdb_*                     : common data bus snoop
//   rob_head, commit_*, flush : ROB control
//   mem_req_* / mem_resp_*    : memory controller handshake
//   res_*                     : load results and store-ready notices
module load_store_buffer
    import load_store_buffer_pkg::*;
#(
    parameter int LSB_BIT = LSB_BIT_P,
    parameter int ROB_BIT = ROB_BIT_P
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               disp_valid,
    input  logic               disp_is_store,
    input  logic [2:0]         disp_funct3,
    input  logic [ROB_BIT-1:0] disp_rob,
    input  logic               disp_data_rdy,
    input  logic [31:0]        disp_data,
    input  logic [ROB_BIT-1:0] disp_data_tag,
    output logic               lsb_full,
    input  logic               addr_valid,
    input  logic [31:0]        addr_value,
    input  logic [ROB_BIT-1:0] addr_rob,
    input  logic               cdb_valid,
    input  logic [ROB_BIT-1:0] cdb_rob,
    input  logic [31:0]        cdb_value,
    input  logic [ROB_BIT-1:0] rob_head,
    input  logic               commit_valid,
    input  logic [ROB_BIT-1:0] commit_rob,
    input  logic               flush,
    output logic               mem_req_valid,
    output logic               mem_req_we,
    output logic [31:0]        mem_req_addr,
    output logic [1:0]         mem_req_size,
    output logic [31:0]        mem_req_wdata,
    input  logic               mem_req_ready,
    input  logic               mem_resp_valid,
    input  logic [31:0]        mem_resp_data,
    output logic               res_valid,
    output logic [ROB_BIT-1:0] res_rob,
    output logic [31:0]        res_value
);

    localparam int                 DEPTH    = 1 << LSB_BIT;
    localparam logic [LSB_BIT:0]   CNT_ONE  = (LSB_BIT+1)'(1);
    localparam logic [LSB_BIT:0]   CNT_FULL = (LSB_BIT+1)'(DEPTH);
    localparam logic [LSB_BIT-1:0] PTR_ONE  = LSB_BIT'(1);

    typedef struct packed {
        logic               valid;
        logic               is_store;
        logic [2:0]         funct3;
        logic [ROB_BIT-1:0] rob;
        logic               addr_rdy;
        logic [31:0]        addr;
        logic               data_rdy;
        logic [31:0]        data;
        logic [ROB_BIT-1:0] data_tag;
        logic               committed;
        logic               notified;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    logic [LSB_BIT-1:0] head_q, head_d, tail_q, tail_d;
    logic [LSB_BIT:0]   count_q, count_d;
    lsb_state_e         state_q, state_d;
    logic               discard_q, discard_d;
    logic               infl_store_q, infl_store_d;
    logic [2:0]         infl_funct3_q, infl_funct3_d;
    logic [ROB_BIT-1:0] infl_rob_q, infl_rob_d;
    logic               mem_req_valid_q, mem_req_valid_d;
    logic               mem_req_we_q, mem_req_we_d;
    logic [31:0]        mem_req_addr_q, mem_req_addr_d;
    logic [1:0]         mem_req_size_q, mem_req_size_d;
    logic [31:0]        mem_req_wdata_q, mem_req_wdata_d;
    logic               res_valid_q, res_valid_d;
    logic [ROB_BIT-1:0] res_rob_q, res_rob_d;
    logic [31:0]        res_value_q, res_value_d;

    entry_t             head_ent_s;
    logic               issue_ok_s, issue_go_s;
    logic               resp_done_s, load_done_s, pop_s, disp_acc_s;
    logic [LSB_BIT:0]   ncommit_s;
    logic               ntc_found_s, notice_fire_s;
    logic [LSB_BIT-1:0] ntc_idx_s;
    logic [31:0]        ext_s;

    lsb_load_ext u_ext (
        .funct3_i (infl_funct3_q),
        .raw_i    (mem_resp_data),
        .ext_o    (ext_s)
    );

    assign lsb_full      = (count_q == CNT_FULL);
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_we    = mem_req_we_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_size  = mem_req_size_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign res_valid     = res_valid_q;
    assign res_rob       = res_rob_q;
    assign res_value     = res_value_q;

    // Head issue eligibility; MMIO loads must be non-speculative
    always_comb begin
        head_ent_s = ent_q[head_q];
        if (!head_ent_s.valid || !head_ent_s.addr_rdy) begin
            issue_ok_s = 1'b0;
        end else if (head_ent_s.is_store) begin
            issue_ok_s = head_ent_s.committed && head_ent_s.data_rdy;
        end else if (is_mmio(head_ent_s.addr)) begin
            issue_ok_s = (head_ent_s.rob == rob_head);
        end else begin
            issue_ok_s = 1'b1;
        end
    end

    // Handshake qualifiers; a load squashed by flush never pops or reports
    always_comb begin
        issue_go_s  = (state_q == ST_IDLE) && issue_ok_s && !flush;
        resp_done_s = (state_q == ST_WAIT) && mem_resp_valid;
        load_done_s = resp_done_s && !infl_store_q && !discard_q && !flush;
        pop_s       = resp_done_s && !discard_q && (infl_store_q || !flush);
        disp_acc_s  = disp_valid && !flush && (!lsb_full || pop_s);
    end

    // Length of the committed-store run starting at head (survives a flush)
    always_comb begin
        logic               run_v;
        logic [LSB_BIT-1:0] idx_v;
        ncommit_s = '0;
        run_v     = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            idx_v = head_q + k[LSB_BIT-1:0];
            if (run_v && (k[LSB_BIT:0] < count_q) && ent_q[idx_v].valid &&
                ent_q[idx_v].is_store && ent_q[idx_v].committed) begin
                ncommit_s = ncommit_s + CNT_ONE;
            end else begin
                run_v = 1'b0;
            end
        end
    end

    // Oldest store with address and data known that has not been reported
    always_comb begin
        logic [LSB_BIT-1:0] idx_v;
        ntc_found_s = 1'b0;
        ntc_idx_s   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_v = head_q + k[LSB_BIT-1:0];
            if (!ntc_found_s && ent_q[idx_v].valid && ent_q[idx_v].is_store &&
                ent_q[idx_v].addr_rdy && ent_q[idx_v].data_rdy && !ent_q[idx_v].notified) begin
                ntc_found_s = 1'b1;
                ntc_idx_s   = idx_v;
            end else begin
                ntc_found_s = ntc_found_s;
            end
        end
        // Load results own the port this cycle; the notice retries later
        notice_fire_s = ntc_found_s && !load_done_s && !flush;
    end

    // Queue next state: flush truncation, operand capture, pop and push
    always_comb begin
        logic [LSB_BIT-1:0] off_v;
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                off_v = LSB_BIT'(i) - head_q;
                if ({1'b0, off_v} >= ncommit_s) begin
                    ent_d[i].valid = 1'b0;
                end else begin
                    ent_d[i].valid = ent_q[i].valid;
                end
            end
            tail_d = head_q + ncommit_s[LSB_BIT-1:0];
            if (pop_s) begin
                ent_d[head_q].valid = 1'b0;
                head_d  = head_q + PTR_ONE;
                count_d = ncommit_s - CNT_ONE;
            end else begin
                count_d = ncommit_s;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].valid) begin
                    if (addr_valid && (ent_q[i].rob == addr_rob)) begin
                        ent_d[i].addr_rdy = 1'b1;
                        ent_d[i].addr     = addr_value;
                    end else begin
                        ent_d[i].addr_rdy = ent_q[i].addr_rdy;
                    end
                    if (cdb_valid && ent_q[i].is_store && !ent_q[i].data_rdy &&
                        (ent_q[i].data_tag == cdb_rob)) begin
                        ent_d[i].data_rdy = 1'b1;
                        ent_d[i].data     = cdb_value;
                    end else begin
                        ent_d[i].data_rdy = ent_q[i].data_rdy;
                    end
                    if (commit_valid && ent_q[i].is_store && (ent_q[i].rob == commit_rob)) begin
                        ent_d[i].committed = 1'b1;
                    end else begin
                        ent_d[i].committed = ent_q[i].committed;
                    end
                end else begin
                    ent_d[i].valid = 1'b0;
                end
            end
            if (notice_fire_s) begin
                ent_d[ntc_idx_s].notified = 1'b1;
            end else begin
                ent_d[ntc_idx_s].notified = ent_q[ntc_idx_s].notified;
            end
            if (pop_s) begin
                ent_d[head_q].valid = 1'b0;
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            // Written after the pop so a full-queue push can reuse the head slot
            if (disp_acc_s) begin
                ent_d[tail_q].valid     = 1'b1;
                ent_d[tail_q].is_store  = disp_is_store;
                ent_d[tail_q].funct3    = disp_funct3;
                ent_d[tail_q].rob       = disp_rob;
                ent_d[tail_q].addr_rdy  = 1'b0;
                ent_d[tail_q].addr      = 32'h0000_0000;
                ent_d[tail_q].data_rdy  = disp_data_rdy || (cdb_valid && (cdb_rob == disp_data_tag));
                ent_d[tail_q].data      = disp_data_rdy ? disp_data : cdb_value;
                ent_d[tail_q].data_tag  = disp_data_tag;
                ent_d[tail_q].committed = 1'b0;
                ent_d[tail_q].notified  = 1'b0;
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            case ({disp_acc_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_go_s) state_d = ST_REQ;
                else            state_d = ST_IDLE;
            end
            ST_REQ: begin
                if (mem_req_ready) state_d = ST_WAIT;
                else               state_d = ST_REQ;
            end
            ST_WAIT: begin
                if (mem_resp_valid) state_d = ST_IDLE;
                else                state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: request fields, result port and in-flight bookkeeping
    always_comb begin
        mem_req_valid_d = mem_req_valid_q;
        mem_req_we_d    = mem_req_we_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_size_d  = mem_req_size_q;
        mem_req_wdata_d = mem_req_wdata_q;
        infl_store_d    = infl_store_q;
        infl_funct3_d   = infl_funct3_q;
        infl_rob_d      = infl_rob_q;
        res_valid_d     = 1'b0;
        res_rob_d       = res_rob_q;
        res_value_d     = res_value_q;
        discard_d       = discard_q;
        if (issue_go_s) begin
            mem_req_valid_d = 1'b1;
            mem_req_we_d    = head_ent_s.is_store;
            mem_req_addr_d  = head_ent_s.addr;
            mem_req_size_d  = head_ent_s.funct3[1:0];
            mem_req_wdata_d = head_ent_s.is_store ? head_ent_s.data : 32'h0000_0000;
            infl_store_d    = head_ent_s.is_store;
            infl_funct3_d   = head_ent_s.funct3;
            infl_rob_d      = head_ent_s.rob;
        end else if ((state_q == ST_REQ) && mem_req_ready) begin
            mem_req_valid_d = 1'b0;
        end else begin
            mem_req_valid_d = mem_req_valid_q;
        end
        if (load_done_s) begin
            res_valid_d = 1'b1;
            res_rob_d   = infl_rob_q;
            res_value_d = ext_s;
        end else if (notice_fire_s) begin
            res_valid_d = 1'b1;
            res_rob_d   = ent_q[ntc_idx_s].rob;
            res_value_d = 32'h0000_0000;
        end else begin
            res_valid_d = 1'b0;
        end
        // A flushed in-flight load still completes its handshake, silently
        if (resp_done_s) begin
            discard_d = 1'b0;
        end else if (flush && (state_q != ST_IDLE) && !infl_store_q) begin
            discard_d = 1'b1;
        end else begin
            discard_d = discard_q;
        end
    end

    // State registers; rdy_in low freezes everything
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            state_q         <= ST_IDLE;
            discard_q       <= 1'b0;
            infl_store_q    <= 1'b0;
            infl_funct3_q   <= 3'b000;
            infl_rob_q      <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= 32'h0000_0000;
            mem_req_size_q  <= 2'b00;
            mem_req_wdata_q <= 32'h0000_0000;
            res_valid_q     <= 1'b0;
            res_rob_q       <= '0;
            res_value_q     <= 32'h0000_0000;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            state_q         <= state_d;
            discard_q       <= discard_d;
            infl_store_q    <= infl_store_d;
            infl_funct3_q   <= infl_funct3_d;
            infl_rob_q      <= infl_rob_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_we_q    <= mem_req_we_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_size_q  <= mem_req_size_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            res_valid_q     <= res_valid_d;
            res_rob_q       <= res_rob_d;
            res_value_q     <= res_value_d;
        end
    end

endmodule

// File: tb/tb_load_store_buffer.sv
module tb_load_store_buffer;
    import load_store_buffer_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        disp_valid, disp_is_store, disp_data_rdy;
    logic [2:0]  disp_funct3;
    logic [3:0]  disp_rob, disp_data_tag;
    logic [31:0] disp_data;
    logic        lsb_full;
    logic        addr_valid;
    logic [31:0] addr_value;
    logic [3:0]  addr_rob;
    logic        cdb_valid;
    logic [3:0]  cdb_rob;
    logic [31:0] cdb_value;
    logic [3:0]  rob_head;
    logic        commit_valid;
    logic [3:0]  commit_rob;
    logic        flush;
    logic        mem_req_valid, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [1:0]  mem_req_size;
    logic        mem_req_ready, mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        res_valid;
    logic [3:0]  res_rob;
    logic [31:0] res_value;

    typedef struct packed {
        logic [3:0]  rob;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    load_store_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .disp_valid(disp_valid), .disp_is_store(disp_is_store), .disp_funct3(disp_funct3),
        .disp_rob(disp_rob), .disp_data_rdy(disp_data_rdy), .disp_data(disp_data),
        .disp_data_tag(disp_data_tag), .lsb_full(lsb_full),
        .addr_valid(addr_valid), .addr_value(addr_value), .addr_rob(addr_rob),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
        .rob_head(rob_head), .commit_valid(commit_valid), .commit_rob(commit_rob),
        .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_size(mem_req_size), .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .res_valid(res_valid), .res_rob(res_rob), .res_value(res_value)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every res_valid pulse must match the oldest expectation
    always @(negedge clk_in) begin
        if (rst_in && res_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL res_unexpected: observed rob=%0d value=%h expected no result", res_rob, res_value);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_rob", 32'(res_rob), 32'(e.rob));
                chk("res_value", res_value, e.value);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_res(input logic [3:0] rob, input logic [31:0] value);
        exp_t e;
        e.rob   = rob;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic disp(input logic st, input logic [2:0] f3, input logic [3:0] rob,
                        input logic drdy, input logic [31:0] d, input logic [3:0] tag);
        disp_valid = 1'b1; disp_is_store = st; disp_funct3 = f3; disp_rob = rob;
        disp_data_rdy = drdy; disp_data = d; disp_data_tag = tag;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic give_addr(input logic [3:0] rob, input logic [31:0] a);
        addr_valid = 1'b1; addr_rob = rob; addr_value = a;
        tick();
        addr_valid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] rob, input logic [31:0] v);
        cdb_valid = 1'b1; cdb_rob = rob; cdb_value = v;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic commit(input logic [3:0] rob);
        commit_valid = 1'b1; commit_rob = rob;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!mem_req_valid && n < 30) begin
            tick();
            n++;
        end
        chk(tag, 32'(mem_req_valid), 32'h1);
    endtask

    task automatic serve(input logic [31:0] raw);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("req_drop", 32'(mem_req_valid), 32'h0);
        mem_resp_valid = 1'b1; mem_resp_data = raw;
        tick();
        mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        tick();
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [3:0] rob, input logic [31:0] a,
                            input logic [31:0] raw, input logic [31:0] exp);
        disp(1'b0, f3, rob, 1'b0, 32'h0, 4'h0);
        give_addr(rob, a);
        wait_req("load_req");
        chk("load_addr", mem_req_addr, a);
        chk("load_we", 32'(mem_req_we), 32'h0);
        chk("load_size", 32'(mem_req_size), 32'(f3[1:0]));
        expect_res(rob, exp);
        serve(raw);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1;
        disp_valid = 1'b0; disp_is_store = 1'b0; disp_funct3 = 3'b000; disp_rob = 4'h0;
        disp_data_rdy = 1'b0; disp_data = 32'h0; disp_data_tag = 4'h0;
        addr_valid = 1'b0; addr_value = 32'h0; addr_rob = 4'h0;
        cdb_valid = 1'b0; cdb_rob = 4'h0; cdb_value = 32'h0;
        rob_head = 4'h0; commit_valid = 1'b0; commit_rob = 4'h0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        ticks(2);
        chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_full", 32'(lsb_full), 32'h0);
        chk("rst_req_addr", mem_req_addr, 32'h0);
        rst_in = 1'b1;
        tick();

        // T1: loads with every extension flavour
        run_load(F3_LB,  4'd2, 32'h100, 32'h0000_0080, 32'hFFFF_FF80);
        run_load(F3_LBU, 4'd2, 32'h100, 32'h0000_0080, 32'h0000_0080);
        run_load(F3_LH,  4'd6, 32'h104, 32'h1234_8001, 32'hFFFF_8001);
        run_load(F3_LHU, 4'd7, 32'h108, 32'h1234_8001, 32'h0000_8001);
        run_load(F3_LW,  4'd8, 32'h10C, 32'hCAFE_BABE, 32'hCAFE_BABE);

        // T2: store data via CDB, notice, then write only after commit
        disp(1'b1, F3_SW, 4'd3, 1'b0, 32'h0, 4'd1);
        cdb(4'd1, 32'h0000_DEAD);
        expect_res(4'd3, 32'h0);
        give_addr(4'd3, 32'h200);
        ticks(4);
        chk("st_no_req_before_commit", 32'(mem_req_valid), 32'h0);
        commit(4'd3);
        wait_req("st_req");
        chk("st_we", 32'(mem_req_we), 32'h1);
        chk("st_addr", mem_req_addr, 32'h200);
        chk("st_wdata", mem_req_wdata, 32'h0000_DEAD);
        chk("st_size", 32'(mem_req_size), 32'h2);
        serve(32'h0);
        // Dispatch coinciding with the producing CDB broadcast
        cdb_valid = 1'b1; cdb_rob = 4'd4; cdb_value = 32'h0000_1234;
        disp(1'b1, F3_SW, 4'd7, 1'b0, 32'h0, 4'd4);
        cdb_valid = 1'b0;
        expect_res(4'd7, 32'h0);
        give_addr(4'd7, 32'h300);
        ticks(2);
        commit(4'd7);
        wait_req("st2_req");
        chk("st2_wdata", mem_req_wdata, 32'h0000_1234);
        serve(32'h0);

        // T3: fill, ignore extra dispatch, pop+push while full, wrap
        for (int r = 0; r < 8; r++) begin
            if (r == 7) chk("full_at_7", 32'(lsb_full), 32'h0);
            disp(1'b0, F3_LW, 4'(r), 1'b0, 32'h0, 4'h0);
        end
        chk("full_at_8", 32'(lsb_full), 32'h1);
        disp(1'b0, F3_LW, 4'd8, 1'b0, 32'h0, 4'h0);
        chk("full_after_extra", 32'(lsb_full), 32'h1);
        give_addr(4'd0, 32'h1000);
        wait_req("full_req0");
        chk("full_addr0", mem_req_addr, 32'h1000);
        expect_res(4'd0, 32'h1000_0000);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h1000_0000;
        disp_valid = 1'b1; disp_is_store = 1'b0; disp_funct3 = F3_LW; disp_rob = 4'd9;
        disp_data_rdy = 1'b0;
        tick();
        mem_resp_valid = 1'b0; disp_valid = 1'b0;
        chk("full_pop_push", 32'(lsb_full), 32'h1);
        for (int r = 1; r < 10; r++) begin
            if (r != 8) begin
                give_addr(4'(r), 32'h1000 + 32'(r * 4));
                wait_req("drain_req");
                chk("drain_addr", mem_req_addr, 32'h1000 + 32'(r * 4));
                expect_res(4'(r), 32'h1000_0000 + 32'(r));
                serve(32'h1000_0000 + 32'(r));
            end
        end
        chk("drained_full", 32'(lsb_full), 32'h0);

        // T4: MMIO load waits for ROB head
        rob_head = 4'd4;
        disp(1'b0, F3_LW, 4'd5, 1'b0, 32'h0, 4'h0);
        give_addr(4'd5, 32'h0003_0000);
        ticks(4);
        chk("mmio_held", 32'(mem_req_valid), 32'h0);
        rob_head = 4'd5;
        wait_req("mmio_req");
        chk("mmio_addr", mem_req_addr, 32'h0003_0000);
        expect_res(4'd5, 32'h55AA_55AA);
        serve(32'h55AA_55AA);
        rob_head = 4'd0;

        // T5: flush keeps the committed store only
        disp(1'b1, F3_SW, 4'd1, 1'b1, 32'h0000_AAAA, 4'h0);
        disp(1'b0, F3_LW, 4'd2, 1'b0, 32'h0, 4'h0);
        disp(1'b0, F3_LW, 4'd3, 1'b0, 32'h0, 4'h0);
        expect_res(4'd1, 32'h0);
        give_addr(4'd1, 32'h400);
        ticks(2);
        commit(4'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int r = 8; r < 15; r++) begin
            if (r == 14) chk("flush_cnt_7", 32'(lsb_full), 32'h0);
            disp(1'b0, F3_LW, 4'(r), 1'b0, 32'h0, 4'h0);
        end
        chk("flush_cnt_8", 32'(lsb_full), 32'h1);
        wait_req("flush_st_req");
        chk("flush_st_we", 32'(mem_req_we), 32'h1);
        chk("flush_st_addr", mem_req_addr, 32'h400);
        serve(32'h0);
        chk("flush_st_pop", 32'(lsb_full), 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        give_addr(4'd2, 32'h800);
        ticks(3);
        chk("flushed_load_gone", 32'(mem_req_valid), 32'h0);
        // Flush during an in-flight load
        disp(1'b0, F3_LW, 4'd4, 1'b0, 32'h0, 4'h0);
        give_addr(4'd4, 32'h500);
        wait_req("infl_req");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        disp(1'b0, F3_LW, 4'd6, 1'b0, 32'h0, 4'h0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        give_addr(4'd6, 32'h504);
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0BAD;
        tick();
        mem_resp_valid = 1'b0;
        ticks(2);
        expect_res(4'd6, 32'h0000_600D);
        wait_req("post_flush_req");
        chk("post_flush_addr", mem_req_addr, 32'h504);
        serve(32'h0000_600D);

        // T6: request stability, stall, reset mid-transaction
        disp(1'b0, F3_LW, 4'd2, 1'b0, 32'h0, 4'h0);
        give_addr(4'd2, 32'h600);
        wait_req("hold_req");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", 32'(mem_req_valid), 32'h1);
            chk("hold_addr", mem_req_addr, 32'h600);
        end
        rdy_in = 1'b0;
        mem_req_ready = 1'b1;
        ticks(3);
        chk("stall_valid", 32'(mem_req_valid), 32'h1);
        rdy_in = 1'b1;
        mem_req_ready = 1'b0;
        expect_res(4'd2, 32'h7777_0001);
        serve(32'h7777_0001);
        disp(1'b0, F3_LW, 4'd3, 1'b0, 32'h0, 4'h0);
        give_addr(4'd3, 32'h700);
        wait_req("rst_req");
        #3;
        rst_in = 1'b0;
        #1;
        chk("async_req_valid", 32'(mem_req_valid), 32'h0);
        chk("async_req_addr", mem_req_addr, 32'h0);
        chk("async_res_rob", 32'(res_rob), 32'h0);
        chk("async_res_value", res_value, 32'h0);
        ticks(2);
        rst_in = 1'b1;
        ticks(4);
        chk("after_rst_req", 32'(mem_req_valid), 32'h0);
        chk("after_rst_full", 32'(lsb_full), 32'h0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
